// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared constants, quadrant encoding and quarter-wave table generator for the multi-channel NCO
// Contents:
//   SAMPLE_SLOT / HALF_SLOT : width of one channel's {sin, cos} slot in tdata and of each half
//   quad_e                  : top two phase bits, selecting mirror and negate for the quarter-wave table
//   LFSR_TAP_A / LFSR_TAP_B : feedback taps (0-based) for x^31 + x^28 + 1
//   lut_entry()             : elaboration-time magnitude of one quarter-wave table entry
package nco_pkg;

    localparam int SAMPLE_SLOT = 32;
    localparam int HALF_SLOT   = SAMPLE_SLOT / 2;

    localparam int LFSR_TAP_A = 30;
    localparam int LFSR_TAP_B = 27;

    typedef enum logic [1:0] {
        Q_RISE     = 2'b00,
        Q_FALL     = 2'b01,
        Q_NEG_RISE = 2'b10,
        Q_NEG_FALL = 2'b11
    } quad_e;

    localparam real PI = 3.14159265358979323846;

    // round((2^(ab-1)-1) * sin(2*pi*(idx+0.5)/2^pb)); the sine is a Taylor
    // series so only basic real arithmetic is needed at elaboration. The
    // argument never exceeds pi/2, where eleven terms are far below 1 LSB.
    function automatic int lut_entry(input int idx, input int pb, input int ab);
        real x;
        real x2;
        real term;
        real s;
        real amp;
        x    = PI * (2.0 * real'(idx) + 1.0) / real'(1 << pb);
        x2   = x * x;
        term = x;
        s    = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x2 / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        amp = real'((1 << (ab - 1)) - 1);
        return $rtoi(s * amp + 0.5);
    endfunction

endpackage

// File: rtl/nco_qlut.sv
// rtl/nco_qlut.sv - quarter-wave sin/cos lookup pipeline for one channel
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_en      : advance enable; every stage holds while low
//   i_phase   : PHASE_BITS phase word (sine phase)
//   o_sin     : signed sine sample, three enabled cycles after i_phase
//   o_cos     : signed cosine sample (phase + quarter turn), same timing
module nco_qlut
    import nco_pkg::*;
#(
    parameter int PHASE_BITS     = 14,
    parameter int AMPLITUDE_BITS = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [PHASE_BITS-1:0]     i_phase,
    output logic [AMPLITUDE_BITS-1:0] o_sin,
    output logic [AMPLITUDE_BITS-1:0] o_cos
);

    localparam int IDX_W = PHASE_BITS - 2;
    localparam int LUT_N = 1 << IDX_W;
    localparam int MAG_W = AMPLITUDE_BITS - 1;

    // Magnitudes only; the sign is restored in the last stage.
    logic [MAG_W-1:0] w_rom [LUT_N];
    for (genvar i = 0; i < LUT_N; i++) begin : g_rom
        localparam int ENTRY = lut_entry(i, PHASE_BITS, AMPLITUDE_BITS);
        assign w_rom[i] = MAG_W'(ENTRY);
    end

    logic [PHASE_BITS-1:0] w_cos_phase;
    assign w_cos_phase = i_phase + PHASE_BITS'(LUT_N);

    // Falling quadrants read the table backwards.
    function automatic logic [IDX_W-1:0] fold_idx(input logic [PHASE_BITS-1:0] p);
        quad_e q;
        q = quad_e'(p[PHASE_BITS-1 -: 2]);
        return (q == Q_FALL || q == Q_NEG_FALL) ? ~p[IDX_W-1:0] : p[IDX_W-1:0];
    endfunction

    function automatic logic is_neg(input logic [PHASE_BITS-1:0] p);
        quad_e q;
        q = quad_e'(p[PHASE_BITS-1 -: 2]);
        return (q == Q_NEG_RISE || q == Q_NEG_FALL);
    endfunction

    logic [IDX_W-1:0] r_sin_addr, r_cos_addr;
    logic             r_sin_neg2, r_cos_neg2;
    logic [MAG_W-1:0] r_sin_mag, r_cos_mag;
    logic             r_sin_neg3, r_cos_neg3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sin_addr <= '0;
            r_cos_addr <= '0;
            r_sin_neg2 <= 1'b0;
            r_cos_neg2 <= 1'b0;
            r_sin_mag  <= '0;
            r_cos_mag  <= '0;
            r_sin_neg3 <= 1'b0;
            r_cos_neg3 <= 1'b0;
            o_sin      <= '0;
            o_cos      <= '0;
        end else if (i_en) begin
            r_sin_addr <= fold_idx(i_phase);
            r_cos_addr <= fold_idx(w_cos_phase);
            r_sin_neg2 <= is_neg(i_phase);
            r_cos_neg2 <= is_neg(w_cos_phase);
            r_sin_mag  <= w_rom[r_sin_addr];
            r_cos_mag  <= w_rom[r_cos_addr];
            r_sin_neg3 <= r_sin_neg2;
            r_cos_neg3 <= r_cos_neg2;
            // Magnitudes stop at 2^(AMPLITUDE_BITS-1)-1, so negation cannot overflow.
            o_sin      <= r_sin_neg3 ? AMPLITUDE_BITS'(0) - {1'b0, r_sin_mag} : {1'b0, r_sin_mag};
            o_cos      <= r_cos_neg3 ? AMPLITUDE_BITS'(0) - {1'b0, r_cos_mag} : {1'b0, r_cos_mag};
        end
    end

endmodule

// File: rtl/axis_nco_multi_v5.sv
// rtl/axis_nco_multi_v5.sv - multi-channel phase-continuous NCO with AXI-Stream output
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cfg_ch/cfg_freq/cfg_phase/cfg_wr : shadow write of one channel's frequency and phase offset
//   cfg_commit               : copy every shadow register into the active set on the next edge
//   phase_sync               : zero all accumulators on the next advancing edge (held if stalled)
//   dither_scale             : mask applied to both dither LFSR words
//   m_axis_tdata/tvalid/tready : output stream, channel k in bits [32k+31:32k] as {sin, cos}
module axis_nco_multi_v5
    import nco_pkg::*;
#(
    parameter int          N_CH           = 2,
    parameter int          ACCUM_WIDTH    = 32,
    parameter int          PHASE_BITS     = 14,
    parameter int          AMPLITUDE_BITS = 14,
    parameter bit          DITHER_EN      = 1'b1,
    parameter logic [31:0] SEED           = 32'd36421,
    parameter logic [31:0] SEED2          = 32'd94352,
    localparam int         CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH_W-1:0]               cfg_ch,
    input  logic [ACCUM_WIDTH-1:0]        cfg_freq,
    input  logic [ACCUM_WIDTH-1:0]        cfg_phase,
    input  logic                          cfg_wr,
    input  logic                          cfg_commit,
    input  logic                          phase_sync,
    input  logic [ACCUM_WIDTH-1:0]        dither_scale,
    output logic [SAMPLE_SLOT*N_CH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int AW = ACCUM_WIDTH;
    localparam int PB = PHASE_BITS;
    localparam int AB = AMPLITUDE_BITS;

    logic w_adv;
    assign w_adv = !m_axis_tvalid || m_axis_tready;

    logic [AW-1:0] r_sh_freq  [N_CH];
    logic [AW-1:0] r_sh_phase [N_CH];
    logic [AW-1:0] r_freq     [N_CH];
    logic [AW-1:0] r_phase    [N_CH];
    logic [AW-1:0] r_acc      [N_CH];
    logic [PB-1:0] r_p        [N_CH];
    logic          r_sync_pend;
    logic [2:0]    r_vld;
    logic [AW-1:0] w_dither;

    // Configuration is not gated by w_adv. A same-cycle write and commit
    // copies the pre-write shadow because both read the old register values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_sh_freq[k]  <= '0;
                r_sh_phase[k] <= '0;
                r_freq[k]     <= '0;
                r_phase[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (cfg_wr && cfg_ch == CH_W'(k)) begin
                    r_sh_freq[k]  <= cfg_freq;
                    r_sh_phase[k] <= cfg_phase;
                end
                if (cfg_commit) begin
                    r_freq[k]  <= r_sh_freq[k];
                    r_phase[k] <= r_sh_phase[k];
                end
            end
        end
    end

    // S0 accumulate and S1 phase word. A sync seen while stalled is parked
    // in r_sync_pend so it still lands on the next advancing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_pend   <= 1'b0;
            r_vld         <= '0;
            m_axis_tvalid <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                r_acc[k] <= '0;
                r_p[k]   <= '0;
            end
        end else if (w_adv) begin
            r_sync_pend            <= 1'b0;
            {m_axis_tvalid, r_vld} <= {r_vld, 1'b1};
            for (int k = 0; k < N_CH; k++) begin
                r_acc[k] <= (phase_sync || r_sync_pend) ? '0 : r_acc[k] + r_freq[k];
                r_p[k]   <= PB'((r_acc[k] + r_phase[k] + w_dither) >> (AW - PB));
            end
        end else if (phase_sync) begin
            r_sync_pend <= 1'b1;
        end
    end

    if (DITHER_EN) begin : g_dither
        logic [31:0] r_lfsr1, r_lfsr2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lfsr1 <= SEED;
                r_lfsr2 <= SEED2;
            end else if (w_adv) begin
                r_lfsr1 <= {r_lfsr1[30:0], r_lfsr1[LFSR_TAP_A] ^ r_lfsr1[LFSR_TAP_B]};
                r_lfsr2 <= {r_lfsr2[30:0], r_lfsr2[LFSR_TAP_A] ^ r_lfsr2[LFSR_TAP_B]};
            end
        end

        // Difference of two masked words gives a zero-mean signed offset.
        assign w_dither = (AW'(r_lfsr1) & dither_scale) - (AW'(r_lfsr2) & dither_scale);
    end else begin : g_no_dither
        logic w_unused_scale;
        assign w_unused_scale = ^dither_scale;
        assign w_dither       = '0;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [AB-1:0] w_sin, w_cos;

        nco_qlut #(
            .PHASE_BITS     (PB),
            .AMPLITUDE_BITS (AB)
        ) u_qlut (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_phase (r_p[k]),
            .o_sin   (w_sin),
            .o_cos   (w_cos)
        );

        assign m_axis_tdata[SAMPLE_SLOT*k +: SAMPLE_SLOT] =
            {HALF_SLOT'($signed(w_sin)), HALF_SLOT'($signed(w_cos))};
    end

endmodule
